// File: rtl/bus_pkg.sv
// Shared types and defaults for the core-to-APB bus masters.
package bus_pkg;

  localparam int          BUS_ADDR_W        = 32;
  localparam int          BUS_DATA_W        = 32;
  localparam logic [31:0] DEF_BASE_ADDR     = 32'h1000_0000;
  localparam int          DEF_SLV_SIZE_LOG2 = 12;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } bus_state_e;

  // Request as latched from the core in IDLE.
  typedef struct packed {
    logic [BUS_ADDR_W-1:0]   addr;
    logic [BUS_DATA_W-1:0]   wdata;
    logic [BUS_DATA_W/8-1:0] be;
    logic                    we;
  } bus_req_t;

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address-to-slave decoder; zero latency, no handshake.
// Windows are 2**SLV_SIZE_LOG2 bytes each, packed upward from BASE_ADDR.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter int                N_SLAVES      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = DEF_BASE_ADDR,
  parameter int                SLV_SIZE_LOG2 = DEF_SLV_SIZE_LOG2,
  parameter int                IDX_W         = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              hit
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] idx_full;

  assign offset   = addr - BASE_ADDR;
  assign idx_full = offset >> SLV_SIZE_LOG2;
  // Below-base addresses wrap to a huge offset, so the lower bound is checked explicitly.
  assign hit      = (addr >= BASE_ADDR) && (idx_full < ADDR_W'(N_SLAVES));
  assign idx      = idx_full[IDX_W-1:0];

endmodule

// File: rtl/apb_bus_master.sv
// Core simple-bus to APB bridge: latency 3 + wait states (1 for unmapped, TIMEOUT+3 on timeout).
// No backpressure to the core: one request at a time, transfer is ignored until back in IDLE.
module apb_bus_master
  import bus_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                N_SLAVES      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = DEF_BASE_ADDR,
  parameter int                SLV_SIZE_LOG2 = DEF_SLV_SIZE_LOG2,
  parameter int                TIMEOUT       = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       transfer,
  input  logic                       busWe,
  input  logic [ADDR_W-1:0]          busAddr,
  input  logic [DATA_W-1:0]          busWData,
  input  logic [DATA_W/8-1:0]        busBe,
  output logic [DATA_W-1:0]          busRData,
  output logic                       ready,
  output logic                       busErr,
  output logic [ADDR_W-1:0]          PADDR,
  output logic [DATA_W-1:0]          PWDATA,
  output logic [DATA_W/8-1:0]        PSTRB,
  output logic                       PWRITE,
  output logic                       PENABLE,
  output logic [N_SLAVES-1:0]        PSEL,
  input  logic [N_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [N_SLAVES-1:0]        PREADY,
  input  logic [N_SLAVES-1:0]        PSLVERR
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [ADDR_W-1:0] OFS_MASK = (ADDR_W'(1) << SLV_SIZE_LOG2) - ADDR_W'(1);

  bus_state_e        state;
  bus_req_t          req;
  logic [IDX_W-1:0]  sel_idx;
  logic [CNT_W-1:0]  wait_cnt;

  logic [IDX_W-1:0]  dec_idx;
  logic              dec_hit;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;

  bus_addr_decoder #(
    .ADDR_W        (ADDR_W),
    .N_SLAVES      (N_SLAVES),
    .BASE_ADDR     (BASE_ADDR),
    .SLV_SIZE_LOG2 (SLV_SIZE_LOG2),
    .IDX_W         (IDX_W)
  ) u_dec (
    .addr (busAddr),
    .idx  (dec_idx),
    .hit  (dec_hit)
  );

  assign sel_ready = PREADY[sel_idx];
  assign sel_err   = PSLVERR[sel_idx];
  assign sel_rdata = PRDATA[sel_idx*DATA_W +: DATA_W];

  // APB address/data come straight from the request register, so they hold from SETUP to RESP.
  assign PADDR  = ADDR_W'(req.addr) & OFS_MASK;
  assign PWDATA = DATA_W'(req.wdata);
  assign PWRITE = req.we;
  assign PSTRB  = req.we ? (DATA_W/8)'(req.be) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req      <= '0;
      sel_idx  <= '0;
      wait_cnt <= '0;
      PSEL     <= '0;
      PENABLE  <= 1'b0;
      ready    <= 1'b0;
      busErr   <= 1'b0;
      busRData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            req.addr  <= BUS_ADDR_W'(busAddr);
            req.wdata <= BUS_DATA_W'(busWData);
            req.be    <= (BUS_DATA_W/8)'(busBe);
            req.we    <= busWe;
            if (dec_hit) begin
              sel_idx  <= dec_idx;
              PSEL     <= N_SLAVES'(1) << dec_idx;
              wait_cnt <= '0;
              state    <= SETUP;
            end else begin
              ready    <= 1'b1;
              busErr   <= 1'b1;
              busRData <= '0;
              state    <= RESP;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // PREADY is checked first so a slave answering on the last allowed cycle still completes.
          if (sel_ready) begin
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            ready    <= 1'b1;
            busErr   <= sel_err;
            busRData <= req.we ? '0 : sel_rdata;
            state    <= RESP;
          end else if ((TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT))) begin
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            ready    <= 1'b1;
            busErr   <= 1'b1;
            busRData <= '0;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          ready  <= 1'b0;
          busErr <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bus_master.sv
// Scoreboard bench for apb_bus_master: randomized requests against a transaction-level model.
module tb_apb_bus_master;

  localparam int          NS   = 4;
  localparam int          TO   = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         transfer, busWe;
  logic [31:0]  busAddr, busWData, busRData;
  logic [3:0]   busBe;
  logic         ready, busErr;
  logic [31:0]  PADDR, PWDATA;
  logic [3:0]   PSTRB, PSEL;
  logic         PWRITE, PENABLE;
  logic [127:0] PRDATA = '0;
  logic [3:0]   PREADY = '0;
  logic [3:0]   PSLVERR = '0;

  apb_bus_master #(
    .ADDR_W(32), .DATA_W(32), .N_SLAVES(NS), .BASE_ADDR(BASE),
    .SLV_SIZE_LOG2(12), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .transfer(transfer), .busWe(busWe),
    .busAddr(busAddr), .busWData(busWData), .busBe(busBe),
    .busRData(busRData), .ready(ready), .busErr(busErr),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        mapped;
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          issue;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          acc = 0;
  logic [31:0] last_rdata = '0;
  logic        psel_seen = 1'b0;
  int          cfg_tgt = 0;
  int          cfg_waits = 0;
  logic        cfg_err = 1'b0;
  logic [31:0] cfg_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: expected event did not happen (cycle %0d)", name, cyc);
  endtask

  // Transaction-level expectation from address map, slave wait count and timeout rule.
  function automatic exp_t model(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                 input logic [3:0] be, input int waits, input logic serr,
                                 input logic [31:0] sdata);
    exp_t        e;
    logic [31:0] slot;
    slot     = (addr - BASE) >> 12;
    e.addr   = addr;
    e.we     = we;
    e.wdata  = wdata;
    e.be     = be;
    e.mapped = (addr >= BASE) && (slot < 32'(NS));
    e.idx    = e.mapped ? int'(slot) : 0;
    e.issue  = 0;
    if (!e.mapped) begin
      e.rdata = '0; e.err = 1'b1; e.lat = 1;
    end else if (waits <= TO) begin
      e.rdata = we ? 32'h0 : sdata; e.err = serr; e.lat = 3 + waits;
    end else begin
      e.rdata = '0; e.err = 1'b1; e.lat = TO + 3;
    end
    return e;
  endfunction

  // Slaves: noise on every input, the target answers after cfg_waits ACCESS cycles.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < NS; k++) begin
      PREADY[k]           = 1'($urandom);
      PSLVERR[k]          = 1'($urandom);
      PRDATA[k*32 +: 32]  = $urandom;
    end
    if (PSEL[cfg_tgt] && PENABLE) begin
      PREADY[cfg_tgt]          = (acc == cfg_waits);
      PSLVERR[cfg_tgt]         = cfg_err;
      PRDATA[cfg_tgt*32 +: 32] = cfg_data;
      acc++;
    end else begin
      acc = 0;
    end
  end

  // Monitor: checks APB phases against the head request and pops on every ready.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (PSEL != '0) psel_seen = 1'b1;
    if (PSEL != '0 && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("psel",    32'(PSEL),    32'(1) << e.idx);
      chk("paddr",   PADDR,        e.addr & 32'hFFF);
      chk("pwrite",  32'(PWRITE),  32'(e.we));
      chk("pstrb",   32'(PSTRB),   e.we ? 32'(e.be) : 32'h0);
      chk("pwdata",  PWDATA,       e.wdata);
      chk("penable", 32'(PENABLE), 32'((cyc - e.issue) > 1));
    end
    if (ready) begin
      if (exp_q.size() == 0) begin
        fail("spurious_ready");
      end else begin
        e = exp_q.pop_front();
        chk("rdata",   busRData,    e.rdata);
        chk("err",     32'(busErr), 32'(e.err));
        chk("latency", cyc - e.issue, e.lat);
        chk("resp_psel", {27'h0, PENABLE, PSEL}, 32'h0);
        if (!e.mapped) chk("unmapped_psel", 32'(psel_seen), 32'h0);
        last_rdata = e.rdata;
        psel_seen  = 1'b0;
      end
    end else begin
      chk("err_idle",   32'(busErr), 32'h0);
      chk("rdata_hold", busRData,    last_rdata);
    end
  end

  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [3:0] be, input int waits, input logic serr,
                       input logic [31:0] sdata);
    exp_t e;
    e = model(addr, we, wdata, be, waits, serr, sdata);
    cfg_tgt   = e.idx;
    cfg_waits = waits;
    cfg_err   = serr;
    cfg_data  = sdata;
    transfer  = 1'b1;
    busWe     = we;
    busAddr   = addr;
    busWData  = wdata;
    busBe     = be;
    e.issue   = cyc;
    exp_q.push_back(e);
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] be, input int waits, input logic serr,
                         input logic [31:0] sdata, input int gap, input logic noise);
    int   n;
    logic got;
    @(negedge clk);
    issue(addr, we, wdata, be, waits, serr, sdata);
    @(negedge clk);
    got = ready;
    // Scramble the core inputs (and optionally re-pulse transfer) while the bridge is busy.
    transfer = noise;
    busAddr  = BASE + ($urandom_range(0, NS - 1) << 12);
    busWData = $urandom;
    busWe    = 1'($urandom);
    busBe    = 4'($urandom);
    n = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      transfer = 1'b0;
      got = ready;
      n++;
    end
    transfer = 1'b0;
    if (!got) fail("resp_timeout");
    repeat (gap) @(negedge clk);
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_psel"},    32'(PSEL),    32'h0);
    chk({tag, "_penable"}, 32'(PENABLE), 32'h0);
    chk({tag, "_ready"},   32'(ready),   32'h0);
    chk({tag, "_buserr"},  32'(busErr),  32'h0);
    chk({tag, "_rdata"},   busRData,     32'h0);
    chk({tag, "_paddr"},   PADDR,        32'h0);
    chk({tag, "_pwdata"},  PWDATA,       32'h0);
    chk({tag, "_pstrb"},   32'(PSTRB),   32'h0);
    chk({tag, "_pwrite"},  32'(PWRITE),  32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          sel;
    logic [31:0] a;
    transfer = 1'b0; busWe = 1'b0; busAddr = '0; busWData = '0; busBe = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    zero_checks("reset");
    #2 reset = 1'b0;

    // Directed cases.
    run_txn(32'h1000_1004, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hDEAD_BEEF, 1, 1'b1);
    run_txn(32'h1000_0008, 1'b1, 32'h1234_5678, 4'b0011, 2, 1'b0, 32'hAAAA_5555, 1, 1'b0);
    run_txn(32'h1000_4000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0, 1'b0);
    run_txn(32'h0FFF_FFFC, 1'b1, 32'h55, 4'hF, 0, 1'b0, 32'h0, 0, 1'b0);
    run_txn(32'h1000_2000, 1'b0, 32'h0, 4'h0, 0, 1'b1, 32'h0BAD_F00D, 0, 1'b0);
    run_txn(32'h1000_3FFC, 1'b0, 32'h0, 4'h0, 99, 1'b0, 32'h1111_2222, 0, 1'b1);
    run_txn(32'h1000_3010, 1'b0, 32'h0, 4'h0, TO, 1'b0, 32'h3333_4444, 0, 1'b0);
    run_txn(32'h1000_1020, 1'b0, 32'h0, 4'h0, TO + 1, 1'b0, 32'h5555_6666, 0, 1'b0);

    // Reset in the middle of an ACCESS wait.
    @(negedge clk);
    issue(32'h1000_2010, 1'b1, 32'hCAFE_F00D, 4'hF, 99, 1'b0, 32'h0);
    @(negedge clk);
    transfer = 1'b0;
    n = 0;
    while (!PENABLE && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!PENABLE) fail("reach_access");
    #2 reset = 1'b1;
    #1 zero_checks("midrst");
    exp_q.delete();
    psel_seen  = 1'b0;
    last_rdata = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (10) @(negedge clk);
    run_txn(32'h1000_2010, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h7777_8888, 0, 1'b0);

    // Randomized traffic, including back-to-back (gap 0) and busy-time transfer pulses.
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = BASE + ($urandom_range(0, NS - 1) << 12) + ($urandom & 32'hFFC);
      else if (sel == 7) a = BASE + (NS << 12) + ($urandom & 32'hFFFC);
      else if (sel == 8) a = BASE - 4 * $urandom_range(1, 1000);
      else               a = $urandom;
      run_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, TO + 2),
              1'($urandom), $urandom, $urandom_range(0, 2), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("pending", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_bus_master.md
# apb_bus_master

Parametrised bus master bridge between the RV32I core's simple bus (`transfer`/`ready` handshake) and N APB-style peripheral slaves (GPIO, UART, timers, ...). It registers each core request, decodes the address into a slave select, runs the APB SETUP/ACCESS sequence, and returns read data plus an error flag. The error flag covers slave errors, unmapped addresses and wait-state timeouts. It replaces the hard-wired single-slave bus glue and adds byte strobes, error reporting and a timeout.

## Interface
- `ADDR_W`, default 32: bus address width.
- `DATA_W`, default 32: bus data width; must be a multiple of 8.
- `N_SLAVES`, default 4: number of APB slaves, 1..16.
- `BASE_ADDR`, default 32'h1000_0000: start of the peripheral region.
- `SLV_SIZE_LOG2`, default 12: log2 of the byte size of each slave window (4 KiB).
- `TIMEOUT`, default 255: maximum ACCESS wait cycles; 0 disables the timeout.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
  - `clk` in 1: the single clock.
  - `reset` in 1: asynchronous, active-high.
- Core-side ports:
  - `transfer` in 1: one-cycle request strobe from the core.
  - `busWe` in 1: 1 = write, 0 = read.
  - `busAddr` in ADDR_W: byte address.
  - `busWData` in DATA_W: write data.
  - `busBe` in DATA_W/8: byte enables; only meaningful on writes.
  - `busRData` out DATA_W: registered read data.
  - `ready` out 1: one-cycle completion pulse.
  - `busErr` out 1: error flag, valid only while `ready` is high.
- APB-side ports:
  - `PADDR` out ADDR_W: address offset within the selected slave window.
  - `PWDATA` out DATA_W: write data.
  - `PSTRB` out DATA_W/8: write strobes.
  - `PWRITE` out 1: transfer direction.
  - `PENABLE` out 1: APB ACCESS phase.
  - `PSEL` out N_SLAVES: one-hot slave select.
  - `PRDATA` in N_SLAVES*DATA_W: slave read data, slave k occupies bits [k*DATA_W +: DATA_W].
  - `PREADY` in N_SLAVES: per-slave ready.
  - `PSLVERR` in N_SLAVES: per-slave error.

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP.
- **IDLE:**
  - `transfer` is sampled only in IDLE and ignored in every other state.
  - On `transfer`=1, latch addr, wdata, we and be, and decode the slave.
  - Mapped address: go to SETUP.
  - Unmapped address: go to RESP with err=1 and rdata=0.
- **Address decode:**
  - Slave index is `(busAddr - BASE_ADDR) >> SLV_SIZE_LOG2`.
  - The address is mapped only if `busAddr >= BASE_ADDR` and the index is < N_SLAVES.
  - `PADDR` = latched address with the upper bits masked to the window offset (low SLV_SIZE_LOG2 bits, zero-extended).
- **SETUP:** `PSEL[idx]`=1, `PENABLE`=0. Unconditionally go to ACCESS.
- **ACCESS:**
  - `PSEL[idx]`=1, `PENABLE`=1; the wait counter increments each cycle.
  - `PREADY[idx]`=1: capture `PRDATA[idx]` (reads only; writes capture 0) and `PSLVERR[idx]`, then go to RESP.
  - Otherwise, if TIMEOUT≠0 and the counter equals TIMEOUT: abort with err=1 and rdata=0, then go to RESP.
- **RESP:**
  - `ready`=1 for exactly one cycle, with `busRData` and `busErr` held valid.
  - `PSEL`=0 and `PENABLE`=0.
  - Return to IDLE.
- **Output stability:** `busRData` keeps its last value until the next RESP. `busErr` is 0 outside RESP.
- **PSTRB:** driven with the latched `busBe` on writes; forced to 0 on reads.
- **Stable APB signals:** `PADDR`, `PWDATA`, `PWRITE` and `PSTRB` stay constant from SETUP through the last ACCESS cycle.
- **Reset (asynchronous, including mid-transfer):**
  - State returns to IDLE and the wait counter clears.
  - Every output goes to 0 immediately: `PSEL`, `PENABLE`, `ready`, `busErr`, `busRData`, `PADDR`, `PWDATA`, `PSTRB`, `PWRITE`.
  - No response is ever produced for an aborted request.

## Timing
- **Zero-wait access:** `transfer` is sampled at edge 0; SETUP runs in cycle 1, ACCESS in cycle 2 (PREADY=1), and `ready` is high in cycle 3. Latency is 3 cycles.
- **With wait states:** each cycle of PREADY=0 adds one cycle, so latency is 3 + waits.
- **Unmapped address:** `ready` with `busErr`=1 in cycle 1. Latency is 1 cycle, and `PSEL` never asserts.
- **Timeout:** `ready` arrives TIMEOUT+3 cycles after the request, with `busErr`=1.
- **Back-to-back requests:** the cycle after RESP is IDLE, so a `transfer` there is accepted. Minimum spacing between mapped requests is 4 cycles.
- **PREADY on the TIMEOUT-th cycle:** it wins over the timeout, so the transfer completes normally.
- **Ignored inputs:** `PREADY`/`PSLVERR` of unselected slaves are ignored.

## Structure
- Package `bus_pkg` holds:
  - `bus_state_e` enum (IDLE, SETUP, ACCESS, RESP);
  - the default base address and window size constants;
  - a `bus_req_t` struct (addr, wdata, be, we) for the latched request.
- Sub-module `bus_addr_decoder`: purely combinational address-to-index/hit decoder, parametrised by N_SLAVES, BASE_ADDR and SLV_SIZE_LOG2. It is reused by the future DMA master.
- Top level: FSM, request register, wait counter and response registers.

## Test plan
- **Zero-wait read:** read of 0x1000_1004 with slave 1 PREADY=1 and PRDATA=0xDEAD_BEEF -> PSEL=0b0010, PADDR=0x004, `ready` in cycle 3, `busRData`=0xDEAD_BEEF, `busErr`=0.
- **Write with 2 wait states:** write to 0x1000_0008 with busWData=0x1234_5678, busBe=0b0011, slave 0 PREADY low for 2 ACCESS cycles -> PWRITE=1, PSTRB=0b0011, PWDATA stable throughout, `ready` at cycle 5.
- **Unmapped addresses:** access to 0x1000_4000 (index 4 with N_SLAVES=4) and to 0x0FFF_FFFC -> PSEL stays 0, `ready` with `busErr`=1 in cycle 1, `busRData`=0.
- **Slave error and timeout (TIMEOUT=4):** (a) PSLVERR=1 with PREADY=1 -> `busErr`=1. (b) PREADY held 0 -> abort, `ready`+`busErr` at cycle 7, `busRData`=0, PSEL drops in RESP.
- **Reset mid-ACCESS:** assert `reset` during an ACCESS wait -> all outputs 0 immediately, no `ready` afterwards, and a new request after reset release completes normally.
- **Back-to-back and busy-ignore:** `transfer` pulsed during SETUP is ignored; a `transfer` in the cycle after RESP (IDLE) is accepted and completes.
